// File: rtl/mem_bus_router_if.sv
// Bundle of CPU request/response, SPI memory controller and peripheral channel
// signals for mem_bus_router. slave = router side, master = surrounding system.
interface mem_bus_router_if #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int NUM_PERIPH   = 4,
  parameter int PERIPH_OFS_W = 4
);
  logic                         req_valid_in;
  logic                         req_ready_out;
  logic                         req_ifetch_in;
  logic                         req_write_in;
  logic [ADDR_W-1:0]            req_addr_in;
  logic [DATA_W-1:0]            req_wdata_in;
  logic                         rsp_valid_out;
  logic [15:0]                  rsp_data_out;
  logic                         rsp_error_out;
  logic                         spi_addr_valid_out;
  logic [1:0]                   spi_mem_type_out;
  logic [ADDR_W-1:0]            spi_addr_out;
  logic [DATA_W-1:0]            spi_wdata_out;
  logic                         spi_busy_in;
  logic [15:0]                  spi_flash_data_in;
  logic                         spi_flash_valid_in;
  logic [DATA_W-1:0]            spi_psram_data_in;
  logic                         spi_psram_valid_in;
  logic [NUM_PERIPH-1:0]        periph_sel_out;
  logic                         periph_write_out;
  logic [PERIPH_OFS_W-1:0]      periph_ofs_out;
  logic [DATA_W-1:0]            periph_wdata_out;
  logic [NUM_PERIPH-1:0]        periph_ready_in;
  logic [NUM_PERIPH*DATA_W-1:0] periph_rdata_in;

  modport slave (
    input  req_valid_in, req_ifetch_in, req_write_in, req_addr_in, req_wdata_in,
    output req_ready_out, rsp_valid_out, rsp_data_out, rsp_error_out,
    output spi_addr_valid_out, spi_mem_type_out, spi_addr_out, spi_wdata_out,
    input  spi_busy_in, spi_flash_data_in, spi_flash_valid_in,
    input  spi_psram_data_in, spi_psram_valid_in,
    output periph_sel_out, periph_write_out, periph_ofs_out, periph_wdata_out,
    input  periph_ready_in, periph_rdata_in
  );

  modport master (
    output req_valid_in, req_ifetch_in, req_write_in, req_addr_in, req_wdata_in,
    input  req_ready_out, rsp_valid_out, rsp_data_out, rsp_error_out,
    input  spi_addr_valid_out, spi_mem_type_out, spi_addr_out, spi_wdata_out,
    output spi_busy_in, spi_flash_data_in, spi_flash_valid_in,
    output spi_psram_data_in, spi_psram_valid_in,
    input  periph_sel_out, periph_write_out, periph_ofs_out, periph_wdata_out,
    output periph_ready_in, periph_rdata_in
  );
endinterface

// File: rtl/mem_bus_router.sv
// Single-outstanding CPU memory router: SPI flash/PSRAM or peripheral channels.
// Optional peripheral wait timeout enabled by defining MEM_BUS_ROUTER_TIMEOUT_EN.
module mem_bus_router #(
  parameter int          ADDR_W       = 16,
  parameter int          DATA_W       = 8,
  parameter int          NUM_PERIPH   = 4,
  parameter logic [3:0]  PERIPH_PAGE  = 4'hF,
  parameter int          PERIPH_OFS_W = 4,
  parameter int          TIMEOUT_CYC  = 64
) (
  input logic              clk_in,
  input logic              reset_n_in,
  mem_bus_router_if.slave  bus
);

  if (NUM_PERIPH < 1 || NUM_PERIPH > 16 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256 || DATA_W > 16)
  begin : g_bad_cfg
    $error("mem_bus_router: parameter out of range");
  end

  localparam logic [1:0] MT_IMEM_READ  = 2'd0;
  localparam logic [1:0] MT_DMEM_READ  = 2'd1;
  localparam logic [1:0] MT_DMEM_WRITE = 2'd2;

  typedef enum logic [2:0] {IDLE, SPI_REQ, SPI_WAIT, PERIPH, RESP} state_t;

  function automatic logic [NUM_PERIPH-1:0] ch_onehot(input logic [3:0] idx);
    logic [NUM_PERIPH-1:0] oh;
    oh = '0;
    for (int k = 0; k < NUM_PERIPH; k++) oh[k] = (idx == 4'(k));
    return oh;
  endfunction

  function automatic logic [15:0] zext16(input logic [DATA_W-1:0] d);
    return 16'(d);
  endfunction

  state_t            state;
  logic [15:0]       data_q;
  logic              err_q;
  logic              busy_seen;
  logic [3:0]        ch_idx;
  logic              page_hit;
  logic              ch_mapped;
  logic              ch_ready;
  logic [DATA_W-1:0] ch_rdata;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
  logic [7:0]        tmo_cnt;
`endif

  assign ch_idx    = bus.req_addr_in[PERIPH_OFS_W +: 4];
  assign page_hit  = (bus.req_addr_in[ADDR_W-1 -: 4] == PERIPH_PAGE);
  assign ch_mapped = ({1'b0, ch_idx} < 5'(NUM_PERIPH));
  // sel is one-hot, so masking with it ignores ready from other channels
  assign ch_ready  = |(bus.periph_sel_out & bus.periph_ready_in);

  always_comb begin
    ch_rdata = '0;
    for (int k = 0; k < NUM_PERIPH; k++)
      if (bus.periph_sel_out[k]) ch_rdata = bus.periph_rdata_in[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state                  <= IDLE;
      data_q                 <= '0;
      err_q                  <= 1'b0;
      busy_seen              <= 1'b0;
      bus.req_ready_out      <= 1'b0;
      bus.rsp_valid_out      <= 1'b0;
      bus.rsp_data_out       <= '0;
      bus.rsp_error_out      <= 1'b0;
      bus.spi_addr_valid_out <= 1'b0;
      bus.spi_mem_type_out   <= '0;
      bus.spi_addr_out       <= '0;
      bus.spi_wdata_out      <= '0;
      bus.periph_sel_out     <= '0;
      bus.periph_write_out   <= 1'b0;
      bus.periph_ofs_out     <= '0;
      bus.periph_wdata_out   <= '0;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
      tmo_cnt                <= '0;
`endif
    end else begin
      bus.rsp_valid_out <= 1'b0;
      bus.rsp_data_out  <= '0;
      bus.rsp_error_out <= 1'b0;
      case (state)
        IDLE: begin
          bus.req_ready_out <= 1'b1;
          if (bus.req_valid_in && bus.req_ready_out) begin
            bus.req_ready_out <= 1'b0;
            data_q            <= '0;
            err_q             <= 1'b0;
            if (bus.req_ifetch_in || !page_hit) begin
              state                  <= SPI_REQ;
              bus.spi_addr_valid_out <= 1'b1;
              bus.spi_mem_type_out   <= bus.req_ifetch_in ? MT_IMEM_READ :
                                        (bus.req_write_in ? MT_DMEM_WRITE : MT_DMEM_READ);
              bus.spi_addr_out       <= bus.req_addr_in;
              bus.spi_wdata_out      <= bus.req_wdata_in;
            end else if (ch_mapped) begin
              state                <= PERIPH;
              bus.periph_sel_out   <= ch_onehot(ch_idx);
              bus.periph_write_out <= bus.req_write_in;
              bus.periph_ofs_out   <= bus.req_addr_in[PERIPH_OFS_W-1:0];
              bus.periph_wdata_out <= bus.req_wdata_in;
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
              tmo_cnt              <= '0;
`endif
            end else begin
              state <= RESP;
              err_q <= 1'b1;
            end
          end
        end
        SPI_REQ: begin
          if (!bus.spi_busy_in) begin
            state                  <= SPI_WAIT;
            bus.spi_addr_valid_out <= 1'b0;
            busy_seen              <= 1'b0;
          end
        end
        SPI_WAIT: begin
          // a write is done once the controller has gone busy and come back idle
          case (bus.spi_mem_type_out)
            MT_IMEM_READ: if (bus.spi_flash_valid_in) begin
              data_q <= bus.spi_flash_data_in;
              state  <= RESP;
            end
            MT_DMEM_READ: if (bus.spi_psram_valid_in) begin
              data_q <= zext16(bus.spi_psram_data_in);
              state  <= RESP;
            end
            default: begin
              if (bus.spi_busy_in) busy_seen <= 1'b1;
              else if (busy_seen)  state     <= RESP;
            end
          endcase
        end
        PERIPH: begin
          if (ch_ready) begin
            data_q               <= bus.periph_write_out ? 16'h0000 : zext16(ch_rdata);
            bus.periph_sel_out   <= '0;
            bus.periph_write_out <= 1'b0;
            state                <= RESP;
          end
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
          else if (tmo_cnt == 8'(TIMEOUT_CYC - 1)) begin
            bus.periph_sel_out   <= '0;
            bus.periph_write_out <= 1'b0;
            err_q                <= 1'b1;
            state                <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          bus.rsp_valid_out <= 1'b1;
          bus.rsp_data_out  <= data_q;
          bus.rsp_error_out <= err_q;
          bus.req_ready_out <= 1'b1;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_router.md
Name: mem_bus_router

Overview:
Parametrised memory-access router between the CPU sequencer and the memory system. Each CPU request is decoded by address and sent either to the SPI flash/PSRAM controller or to one of NUM_PERIPH peripheral channels in the peripheral page. The block completes the peripheral path that the current top level leaves unconnected. It runs a single outstanding transaction, uses a valid/ready request and pulsed response, and reports errors for unmapped channels and peripheral timeouts.

Parameters:
ADDR_W, 16, address width.
DATA_W, 8, data-memory/peripheral data width.
NUM_PERIPH, 4, number of peripheral channels (1..16).
PERIPH_PAGE, 4'hF, value of addr[ADDR_W-1:ADDR_W-4] selecting the peripheral window.
PERIPH_OFS_W, 4, per-channel register offset width; channel index = addr[PERIPH_OFS_W +: 4].
TIMEOUT_CYC, 64, peripheral wait limit in cycles (used only with the optional feature).

Ports:
clk_in  in  1  clock
reset_n_in  in  1  asynchronous active-low reset
req_valid_in  in  1  CPU request valid
req_ready_out  out  1  request accepted (valid&ready)
req_ifetch_in  in  1  instruction fetch (16-bit flash read)
req_write_in  in  1  data write (ignored if ifetch)
req_addr_in  in  ADDR_W  address
req_wdata_in  in  DATA_W  write data
rsp_valid_out  out  1  one-cycle completion pulse
rsp_data_out  out  16  fetch data; data reads zero-extended in [DATA_W-1:0]
rsp_error_out  out  1  qualified by rsp_valid_out
spi_addr_valid_out  out  1  SPI request strobe
spi_mem_type_out  out  2  0=IMEM_READ 1=DMEM_READ 2=DMEM_WRITE
spi_addr_out  out  ADDR_W  SPI address
spi_wdata_out  out  DATA_W  SPI write data
spi_busy_in  in  1  controller busy
spi_flash_data_in  in  16  fetch data
spi_flash_valid_in  in  1  fetch data valid pulse
spi_psram_data_in  in  DATA_W  read data
spi_psram_valid_in  in  1  read data valid pulse
periph_sel_out  out  NUM_PERIPH  one-hot channel select
periph_write_out  out  1  write strobe qualifier
periph_ofs_out  out  PERIPH_OFS_W  register offset
periph_wdata_out  out  DATA_W  write data
periph_ready_in  in  NUM_PERIPH  per-channel ready
periph_rdata_in  in  NUM_PERIPH*DATA_W  per-channel read data, channel k at [k*DATA_W +: DATA_W]

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-transaction aborts it immediately with no response.
- FSM states: IDLE, SPI_REQ, SPI_WAIT, PERIPH, RESP.
- IDLE: req_ready_out=1. On valid&ready, latch ifetch/write/addr/wdata and decode:
  - ifetch: go to SPI_REQ as IMEM_READ.
  - data access with page != PERIPH_PAGE: go to SPI_REQ as DMEM_READ or DMEM_WRITE.
  - data access with page == PERIPH_PAGE and channel index < NUM_PERIPH: go to PERIPH.
  - data access with page == PERIPH_PAGE and index >= NUM_PERIPH: go to RESP with error=1, data=0.
- SPI_REQ: drive spi_addr_valid_out=1 with the latched type, address and data. Stay while spi_busy_in=1; move to SPI_WAIT on the first cycle spi_busy_in=0. spi_addr_valid_out deasserts on leaving.
- SPI_WAIT:
  - IMEM_READ completes on spi_flash_valid_in; DMEM_READ completes on spi_psram_valid_in. Capture data, go to RESP.
  - DMEM_WRITE completes on the first cycle spi_busy_in=0 after it has been seen at 1.
  - Valid pulses of the wrong kind are ignored.
- PERIPH: periph_sel_out one-hot for the latched channel, plus ofs/wdata/write. Complete when periph_ready_in[ch]=1: capture rdata (0 for writes), deassert sel the next cycle, go to RESP.
- RESP: rsp_valid_out=1 for exactly one cycle, rsp_data/rsp_error held that cycle, then return to IDLE. req_ready_out=0 in every state except IDLE.
- Latency: unmapped channel 2 cycles from accept to rsp_valid; a zero-wait peripheral 3 cycles.
- Ready from non-selected channels is ignored.

Optional Feature:
MEM_BUS_ROUTER_TIMEOUT_EN:
- Defined: an 8-bit counter clears on entry to PERIPH and increments each cycle. When it reaches TIMEOUT_CYC-1 without ready, deassert sel and go to RESP with error=1, data=0. Ready arriving on the final cycle wins.
- Undefined: PERIPH waits indefinitely and the counter is absent.

Test Plan:
- Reset mid-PERIPH: assert reset_n_in=0 during a PERIPH wait -> all outputs 0 immediately, no rsp_valid after release.
- Fetch: req ifetch addr 0x0120, controller busy 5 cycles then flash_valid with 0xA55A -> spi_mem_type_out=0, spi_addr_out=0x0120, single rsp_valid with data 0xA55A, error 0.
- PSRAM write: write 0x3C to 0x2004 -> DMEM_WRITE with wdata 0x3C, rsp_valid after busy rises then falls; a stray flash_valid in SPI_WAIT is ignored.
- Peripheral read: read 0xF023, channel 2 ready after 3 cycles with rdata 0x7E -> periph_sel_out=4'b0100, ofs=3, rsp_data=0x007E; channel 1 ready asserted meanwhile is ignored.
- Unmapped channel: read 0xF050 with NUM_PERIPH=4 -> no sel and no SPI activity, rsp_valid 2 cycles after accept with error=1.
- Timeout (macro defined, TIMEOUT_CYC=64): channel 0 never ready -> error response, sel low after 64 cycles. Ready in cycle 64 -> normal response with data.
